// File: rtl/led_count_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : led_count_controller_if
// Brief    : Button/LED signal bundle for the LED counter controller.
// Revision : 1.0 - initial release
// ============================================================================
interface led_count_controller_if;
  logic [1:0] button;
  logic [3:0] led;
  logic       tick;
  logic       running;
  logic [1:0] rate_sel;

  modport master (
    output button,
    input  led,
    input  tick,
    input  running,
    input  rate_sel
  );

  modport slave (
    input  button,
    output led,
    output tick,
    output running,
    output rate_sel
  );
endinterface
`default_nettype wire

// File: rtl/led_count_controller.sv
`default_nettype none
// ============================================================================
// Module   : led_count_controller
// Brief    : Debounced run/pause/clear control and selectable-rate prescaler
//            driving a 4-bit LED counter, single clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module led_count_controller #(
  parameter int CLK_HZ          = 12000000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input wire                    clk,
  input wire                    rst,
  led_count_controller_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(CLK_HZ);

  localparam logic [DW-1:0] c_db_last  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] c_last_r0  = PW'((CLK_HZ >> 0) - 1);
  localparam logic [PW-1:0] c_last_r1  = PW'((CLK_HZ >> 1) - 1);
  localparam logic [PW-1:0] c_last_r2  = PW'((CLK_HZ >> 2) - 1);
  localparam logic [PW-1:0] c_last_r3  = PW'((CLK_HZ >> 3) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    w_press;
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_led;
  logic [1:0]    r_rate;
  logic          r_running;
  logic [PW-1:0] w_last;
  logic          w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end

  // Press pulse is registered alongside the stable flip so both land in the same cycle.
  for (genvar g = 0; g < 2; g++) begin : g_debounce
    logic [DW-1:0] r_cnt;
    logic          r_stable;
    logic          r_press;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt    <= '0;
        r_stable <= 1'b1;
        r_press  <= 1'b0;
      end else begin
        r_press <= 1'b0;
        if (r_sync2[g] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_last) begin
          r_stable <= r_sync2[g];
          r_cnt    <= '0;
          r_press  <= ~r_sync2[g];
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
    end

    assign w_press[g] = r_press;
  end

  always_comb begin
    w_last = c_last_r0;
    case (r_rate)
      2'd0:    w_last = c_last_r0;
      2'd1:    w_last = c_last_r1;
      2'd2:    w_last = c_last_r2;
      default: w_last = c_last_r3;
    endcase
  end

  // A rate change (or clear) restarts the period, so it must also swallow a pending tick.
  assign w_tick = (r_state == S_RUN) && !w_press[1] && (r_presc == w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_led     <= 4'd0;
      r_rate    <= 2'd0;
    end else if (&w_press) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_led     <= 4'd0;
    end else if (w_press[1]) begin
      r_rate  <= r_rate + 2'd1;
      r_presc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          if (w_press[0]) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            r_presc <= '0;
            r_led   <= r_led + 4'd1;
          end else begin
            r_presc <= r_presc + PW'(1);
          end
          if (w_press[0]) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (w_press[0]) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led      = r_led;
  assign bus.tick     = w_tick;
  assign bus.running  = r_running;
  assign bus.rate_sel = r_rate;

endmodule
`default_nettype wire

// File: tb/tb_led_count_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_count_controller
// Brief    : Randomized self-checking bench against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_count_controller;

  localparam int CLK_HZ = 16;
  localparam int DEB    = 4;

  logic clk = 1'b0;
  logic rst;

  led_count_controller_if bus_if ();

  led_count_controller #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 run, 2 pause; m_remain = cycles left until next tick
  int         m_state;
  int         m_led;
  int         m_rate;
  int         m_remain;
  logic [1:0] m_stable;
  logic [1:0] m_press;
  logic [1:0] m_hist [0:DEB];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int period(input int r);
    return CLK_HZ >> r;
  endfunction

  function automatic logic exp_tick();
    return (m_state == 1) && !m_press[1] && (m_remain == 1);
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_led    = 0;
    m_rate   = 0;
    m_remain = CLK_HZ;
    m_stable = 2'b11;
    m_press  = 2'b00;
    for (int k = 0; k <= DEB; k++) m_hist[k] = 2'b11;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [1:0] raw);
    logic       tk;
    logic [1:0] np;
    logic       all_diff;
    tk = exp_tick();
    if (&m_press) begin
      m_led    = 0;
      m_state  = 0;
      m_remain = period(m_rate);
    end else if (m_press[1]) begin
      m_rate   = (m_rate + 1) % 4;
      m_remain = period(m_rate);
    end else begin
      if (m_state == 1) begin
        if (tk) begin
          m_led    = (m_led + 1) % 16;
          m_remain = period(m_rate);
        end else begin
          m_remain = m_remain - 1;
        end
      end
      if (m_press[0]) m_state = (m_state == 1) ? 2 : 1;
    end
    // A button flips once the last DEB synchronized samples all disagree with it
    np = 2'b00;
    for (int b = 0; b < 2; b++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= DEB; k++)
        if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) begin
        np[b]       = m_stable[b];
        m_stable[b] = ~m_stable[b];
      end
    end
    for (int k = DEB; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = raw;
    m_press   = np;
  endtask

  task automatic cycle(input logic [1:0] b);
    bus_if.button = b;
    @(negedge clk);
    check("tick",     32'(bus_if.tick),     32'(exp_tick()));
    check("led",      32'(bus_if.led),      m_led);
    check("running",  32'(bus_if.running),  32'(m_state == 1));
    check("rate_sel", 32'(bus_if.rate_sel), m_rate);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(b);
    #1;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    repeat (n) cycle(v);
  endtask

  task automatic wait_led(input int target, input int budget);
    int n = 0;
    while (m_led != target && n < budget) begin
      cycle(2'b11);
      n++;
    end
    check("wait_led", 32'(bus_if.led), target);
  endtask

  initial begin
    logic [1:0] v;
    int         len;

    rst           = 1'b1;
    bus_if.button = 2'b11;
    model_reset();
    hold(2'b11, 3);
    rst = 1'b0;
    hold(2'b11, 5);

    // Bounce: two short lows must not register
    hold(2'b10, 3);
    hold(2'b11, 1);
    hold(2'b10, 3);
    hold(2'b11, 10);
    check("bounce_idle", 32'(bus_if.running), 0);

    // Start, then run long enough for led to wrap
    hold(2'b10, 10);
    hold(2'b11, 10);
    check("start_running", 32'(bus_if.running), 1);
    hold(2'b11, 280);

    // Step through all four rates back to 0
    repeat (4) begin
      hold(2'b01, 10);
      hold(2'b11, 40);
    end
    check("rate_wrap", 32'(bus_if.rate_sel), 0);

    // Pause, idle a while, resume
    hold(2'b10, 10);
    hold(2'b11, 50);
    check("paused", 32'(bus_if.running), 0);
    hold(2'b10, 10);
    hold(2'b11, 40);

    // Clear with rate 2 keeps the rate
    hold(2'b01, 10);
    hold(2'b11, 10);
    hold(2'b01, 10);
    hold(2'b11, 10);
    wait_led(7, 200);
    hold(2'b00, 10);
    hold(2'b11, 10);
    check("clear_led",     32'(bus_if.led),      0);
    check("clear_running", 32'(bus_if.running),  0);
    check("clear_rate",    32'(bus_if.rate_sel), 2);

    // Random button activity, including glitches and simultaneous presses
    hold(2'b10, 10);
    hold(2'b11, 10);
    repeat (150) begin
      v   = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      len = $urandom_range(1, 14);
      hold(v, len);
    end
    hold(2'b11, 20);

    // Asynchronous reset in the middle of a run with led = 5
    for (int a = 0; a < 4 && m_state != 1; a++) begin
      hold(2'b10, 10);
      hold(2'b11, 10);
    end
    wait_led(5, 600);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_led",      32'(bus_if.led),      0);
    check("rst_running",  32'(bus_if.running),  0);
    check("rst_rate_sel", 32'(bus_if.rate_sel), 0);
    check("rst_tick",     32'(bus_if.tick),     0);
    hold(2'b11, 2);
    rst = 1'b0;
    hold(2'b11, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
